// File: rtl/adder_multicycle.sv
// adder_multicycle: multi-cycle WIDTH-bit adder/subtractor, one CHUNK-bit slice per clock.
// Ports: clk, rst_n (async low); in_valid/in_ready, operand1, operand2, carry_in, subtract;
//        out_valid/out_ready, result, carry_out (sub: 1 = no borrow), overflow, zero.
module adder_multicycle #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             carry_in,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              carry_q, carry_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_out_q, carry_out_d;
    logic              overflow_q, overflow_d;
    logic              zero_q, zero_d;

    logic [CHUNK-1:0]  a_sl;
    logic [CHUNK-1:0]  b_sl;
    logic [CHUNK:0]    sum;
    logic              msb_cin;

    // The single shared slice adder.
    assign a_sl = a_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign b_sl = b_q[int'(cnt_q)*CHUNK +: CHUNK];
    assign sum  = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the slice MSB recovered from the MSB sum bit.
    assign msb_cin = a_sl[CHUNK-1] ^ b_sl[CHUNK-1] ^ sum[CHUNK-1];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = operand1;
                    b_d     = subtract ? ~operand2 : operand2;
                    carry_d = carry_in ^ subtract;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                result_d[int'(cnt_q)*CHUNK +: CHUNK] = sum[CHUNK-1:0];
                carry_d = sum[CHUNK];
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d       = '0;
                    state_d     = DONE;
                    carry_out_d = sum[CHUNK];
                    overflow_d  = msb_cin ^ sum[CHUNK];
                    zero_d      = (result_d == '0);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_adder_multicycle.sv
// tb_adder_multicycle: directed and randomised checks of adder_multicycle (WIDTH=32, CHUNK=8).
// Ports: none; drives the DUT from one initial block and prints a pass summary.
module tb_adder_multicycle;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] operand1 = '0;
    logic [31:0] operand2 = '0;
    logic        carry_in = 1'b0;
    logic        subtract = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;
    logic        zero;

    int checks = 0;
    int passed = 0;

    adder_multicycle #(.WIDTH(32), .CHUNK(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand1  (operand1),
        .operand2  (operand2),
        .carry_in  (carry_in),
        .subtract  (subtract),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request, take it at the next edge, then count cycles to out_valid.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input logic ci, input logic sub, output int lat);
        operand1 = a;
        operand2 = b;
        carry_in = ci;
        subtract = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("consume_out_valid", {31'd0, out_valid}, 32'd0);
        chk("consume_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        int lat;
        logic [31:0] hold;
        logic [32:0] wide;
        logic [31:0] ea, eb, er;
        logic        eci, esub, eco, eov;

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_flags", {29'd0, carry_out, overflow, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Carry wrap to zero.
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        chk("wrap_lat", lat, 4);
        chk("wrap_result", result, 32'h0000_0000);
        chk("wrap_flags", {29'd0, carry_out, overflow, zero}, 32'b101);
        consume();

        // Signed overflow on add.
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, lat);
        chk("ovf_lat", lat, 4);
        chk("ovf_result", result, 32'h8000_0000);
        chk("ovf_flags", {29'd0, carry_out, overflow, zero}, 32'b010);
        consume();

        // 5 - 7 borrows.
        run_op(32'd5, 32'd7, 1'b0, 1'b1, lat);
        chk("sub_lat", lat, 4);
        chk("sub_result", result, 32'hFFFF_FFFE);
        chk("sub_flags", {29'd0, carry_out, overflow, zero}, 32'b000);
        consume();

        // Subtract with borrow-in: 10 - 3 - 1 = 6, no borrow.
        run_op(32'd10, 32'd3, 1'b1, 1'b1, lat);
        chk("subb_result", result, 32'd6);
        chk("subb_flags", {29'd0, carry_out, overflow, zero}, 32'b100);
        consume();

        // Backpressure with a new request waiting.
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, lat);
        chk("bp_result", result, 32'h2345_6789);
        hold = result;
        operand1 = 32'd100;
        operand2 = 32'd23;
        carry_in = 1'b0;
        subtract = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_hold", result, hold);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
        chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_accepted", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        chk("bp2_lat", lat, 4);
        chk("bp2_result", result, 32'd123);
        consume();

        // Reset in the second BUSY cycle aborts the operation.
        operand1 = 32'hAAAA_AAAA;
        operand2 = 32'h5555_5555;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            lat += int'(out_valid);
        end
        chk("abort_no_valid", lat, 0);
        run_op(32'd3, 32'd4, 1'b0, 1'b0, lat);
        chk("post_abort_lat", lat, 4);
        chk("post_abort_result", result, 32'd7);
        consume();

        // Random operations against a (WIDTH+1)-bit arithmetic model.
        for (int n = 0; n < 60; n++) begin
            ea   = $urandom;
            eb   = $urandom;
            eci  = 1'($urandom_range(0, 1));
            esub = 1'($urandom_range(0, 1));
            if (n % 7 == 0) eb = ea;
            if (esub) begin
                wide = {1'b0, ea} - {1'b0, eb} - {32'd0, eci};
                eco  = ~wide[32];
                eov  = (ea[31] != eb[31]) && (wide[31] != ea[31]);
            end else begin
                wide = {1'b0, ea} + {1'b0, eb} + {32'd0, eci};
                eco  = wide[32];
                eov  = (ea[31] == eb[31]) && (wide[31] != ea[31]);
            end
            er = wide[31:0];
            run_op(ea, eb, eci, esub, lat);
            chk("rnd_lat", lat, 4);
            chk("rnd_result", result, er);
            chk("rnd_flags", {29'd0, carry_out, overflow, zero},
                {29'd0, eco, eov, er == 32'd0});
            for (int s = $urandom_range(0, 3); s > 0; s--) tick();
            chk("rnd_stall_hold", result, er);
            consume();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
